// File: rtl/reg_wb_ctrl_pkg.sv
// Shared types and constants for the register write-back controller.
package wb_pkg;

  typedef logic [3:0] reg_addr_t;

  localparam reg_addr_t PC_REG    = 4'd15;
  localparam int        NUM_REGS  = 16;
  localparam int        WB_DATA_W = 32;

  // One register-file write: destination and value.
  typedef struct packed {
    reg_addr_t              addr;
    logic [WB_DATA_W-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Bundle of ALU, load-issue, DMEM-return and register-file write signals.
interface reg_wb_ctrl_if #(parameter int DATA_W = 32);
  import wb_pkg::*;

  logic                    alu_valid;
  logic                    alu_ready;
  reg_addr_t               alu_rd;
  logic [DATA_W-1:0]       alu_result;
  logic                    ld_issue;
  logic                    ld_ready;
  reg_addr_t               ld_rd;
  logic                    dmem_rvalid;
  logic [DATA_W-1:0]       dmem_rdata;
  logic                    wr_en;
  reg_addr_t               wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    pc_wr;
  logic [NUM_REGS-1:0]     pending_mask;
  logic                    err_orphan;

  // Write-back controller side.
  modport slave (
    input  alu_valid, alu_rd, alu_result, ld_issue, ld_rd, dmem_rvalid, dmem_rdata,
    output alu_ready, ld_ready, wr_en, wr_addr, wr_data, pc_wr, pending_mask, err_orphan
  );

  // Pipeline / environment side.
  modport master (
    output alu_valid, alu_rd, alu_result, ld_issue, ld_rd, dmem_rvalid, dmem_rdata,
    input  alu_ready, ld_ready, wr_en, wr_addr, wr_data, pc_wr, pending_mask, err_orphan
  );

endinterface

// File: rtl/reg_wb_ctrl_tag_fifo.sv
// In-order FIFO of outstanding load destinations. Every entry is exposed
// so the parent can build the pending-load mask. A push into a full FIFO is
// taken only when a pop happens in the same cycle.
module wb_tag_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  reg_addr_t  din,
  output reg_addr_t  dout,
  output logic       full,
  output logic       empty,
  output logic [DEPTH-1:0] ent_valid,
  output reg_addr_t  ent_data [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  reg_addr_t        mem_q [DEPTH];
  reg_addr_t        mem_d [DEPTH];
  logic             push_ok, pop_ok;

  assign full      = &valid_q;
  assign empty     = ~|valid_q;
  assign dout      = mem_q[rd_ptr_q];
  assign ent_valid = valid_q;
  assign ent_data  = mem_q;

  // Next pointers, valid flags and storage; pop clears before push sets so a
  // full-FIFO push/pop pair reuses the head slot.
  always_comb begin
    push_ok  = push && (!full || pop);
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    mem_d    = mem_q;
    if (pop_ok) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push_ok) begin
      valid_d[wr_ptr_q] = 1'b1;
      mem_d[wr_ptr_q]   = din;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-back controller: merges non-stallable load returns and
// stallable ALU results onto one write port, tracks outstanding load
// destinations and flags r15 writes.
module reg_wb_ctrl
  import wb_pkg::*;
#(
  parameter int LD_DEPTH = 4,
  parameter int DATA_W   = 32
) (
  input  logic          clk,
  input  logic          rst,
  reg_wb_ctrl_if.slave  bus
);

  logic              fifo_full, fifo_empty;
  reg_addr_t         head_rd;
  logic [LD_DEPTH-1:0] ent_valid;
  reg_addr_t         ent_rd [LD_DEPTH];

  logic              skid_full_q, skid_full_d;
  wb_req_t           skid_q, skid_d;
  logic              wr_en_q, wr_en_d;
  reg_addr_t         wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              pc_wr_q, pc_wr_d;
  logic              err_orphan_q, err_orphan_d;
  logic              ld_wr, alu_acc;
  logic [NUM_REGS-1:0] pending;

  wb_tag_fifo #(.DEPTH(LD_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.ld_issue),
    .pop       (bus.dmem_rvalid),
    .din       (bus.ld_rd),
    .dout      (head_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_valid (ent_valid),
    .ent_data  (ent_rd)
  );

  assign bus.ld_ready     = !fifo_full;
  assign bus.alu_ready    = !skid_full_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.pc_wr        = pc_wr_q;
  assign bus.err_orphan   = err_orphan_q;
  assign bus.pending_mask = pending;

  // OR of one-hot destinations over every outstanding load.
  always_comb begin
    pending = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (ent_valid[i]) pending[ent_rd[i]] = 1'b1;
    end
  end

  // Write-source arbitration: load return, then skid entry, then fresh ALU.
  always_comb begin
    ld_wr        = bus.dmem_rvalid && !fifo_empty;
    alu_acc      = bus.alu_valid && !skid_full_q;
    skid_full_d  = skid_full_q;
    skid_d       = skid_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (ld_wr) begin
      wr_en_d   = 1'b1;
      wr_addr_d = head_rd;
      wr_data_d = bus.dmem_rdata;
      if (alu_acc) begin
        skid_full_d = 1'b1;
        skid_d      = '{addr: bus.alu_rd, data: bus.alu_result};
      end
    end else if (skid_full_q) begin
      wr_en_d     = 1'b1;
      wr_addr_d   = skid_q.addr;
      wr_data_d   = skid_q.data;
      skid_full_d = 1'b0;
    end else if (alu_acc) begin
      wr_en_d   = 1'b1;
      wr_addr_d = bus.alu_rd;
      wr_data_d = bus.alu_result;
    end
    pc_wr_d      = wr_en_d && (wr_addr_d == PC_REG);
    err_orphan_d = err_orphan_q || (bus.dmem_rvalid && fifo_empty);
  end

  // Skid, output and sticky-error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_full_q  <= 1'b0;
      skid_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      pc_wr_q      <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      skid_full_q  <= skid_full_d;
      skid_q       <= skid_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      pc_wr_q      <= pc_wr_d;
      err_orphan_q <= err_orphan_d;
    end
  end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Scoreboard bench for reg_wb_ctrl: stimulus queues expected writes, a
// negedge monitor pops and compares each register-file write.
module tb_reg_wb_ctrl;
  import wb_pkg::*;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    logic        pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [$];

  reg_wb_ctrl_if #(.DATA_W(32)) bus ();

  reg_wb_ctrl #(.LD_DEPTH(4), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    e.a  = a;
    e.d  = d;
    e.pc = (a == 4'd15);
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"},      32'(bus.wr_en),        32'd0);
    chk({tag, "_pc_wr"},      32'(bus.pc_wr),        32'd0);
    chk({tag, "_err_orphan"}, 32'(bus.err_orphan),   32'd0);
    chk({tag, "_wr_addr"},    32'(bus.wr_addr),      32'd0);
    chk({tag, "_wr_data"},    bus.wr_data,           32'd0);
    chk({tag, "_pending"},    32'(bus.pending_mask), 32'd0);
    chk({tag, "_alu_ready"},  32'(bus.alu_ready),    32'd1);
    chk({tag, "_ld_ready"},   32'(bus.ld_ready),     32'd1);
  endtask

  // Monitor: every write seen must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h expected no write", bus.wr_addr, bus.wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("mon_wr_addr", 32'(bus.wr_addr), 32'(e.a));
          chk("mon_wr_data", bus.wr_data, e.d);
          chk("mon_pc_wr",   32'(bus.pc_wr), 32'(e.pc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  rds1 [4];
    logic [15:0] masks1 [4];
    logic [3:0]  rds2 [4];
    rds1   = '{4'd1, 4'd2, 4'd3, 4'd1};
    masks1 = '{16'h000E, 16'h000A, 16'h0002, 16'h0000};
    rds2   = '{4'd2, 4'd3, 4'd4, 4'd7};

    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_result = 0;
    bus.ld_issue = 0; bus.ld_rd = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = 0;

    #3;
    chk_reset_vals("rst_init");
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("idle_wr_en", 32'(bus.wr_en), 32'd0);

    // ALU only
    bus.alu_valid = 1; bus.alu_rd = 4'd3; bus.alu_result = 32'hDEADBEEF;
    expect_wr(4'd3, 32'hDEADBEEF);
    chk("alu_ready_pre", 32'(bus.alu_ready), 32'd1);
    cyc();
    bus.alu_valid = 0;
    chk("alu_lat1_wr_en", 32'(bus.wr_en), 32'd1);
    cyc();
    chk("alu_idle_wr_en", 32'(bus.wr_en), 32'd0);
    chk("alu_idle_hold_addr", 32'(bus.wr_addr), 32'd3);

    // Collision: load return vs ALU in the same cycle
    bus.ld_issue = 1; bus.ld_rd = 4'd5;
    cyc();
    bus.ld_issue = 0;
    chk("coll_pending", 32'(bus.pending_mask), 32'h20);
    bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h11;
    bus.alu_valid = 1; bus.alu_rd = 4'd2; bus.alu_result = 32'h22;
    expect_wr(4'd5, 32'h11);
    expect_wr(4'd2, 32'h22);
    cyc();
    bus.dmem_rvalid = 0; bus.alu_valid = 0;
    chk("coll_c1_wr_en",     32'(bus.wr_en),        32'd1);
    chk("coll_c1_alu_ready", 32'(bus.alu_ready),    32'd0);
    chk("coll_c1_pending",   32'(bus.pending_mask), 32'd0);
    cyc();
    chk("coll_c2_wr_en",     32'(bus.wr_en),     32'd1);
    chk("coll_c2_alu_ready", 32'(bus.alu_ready), 32'd1);
    cyc();

    // Fill the load FIFO with a duplicate destination, then drain
    for (int i = 0; i < 4; i++) begin
      bus.ld_issue = 1; bus.ld_rd = rds1[i];
      cyc();
    end
    bus.ld_issue = 0;
    chk("full_ld_ready", 32'(bus.ld_ready),     32'd0);
    chk("full_pending",  32'(bus.pending_mask), 32'h000E);
    for (int i = 0; i < 4; i++) begin
      bus.dmem_rvalid = 1; bus.dmem_rdata = 32'hA1 + 32'(i);
      expect_wr(rds1[i], 32'hA1 + 32'(i));
      cyc();
      bus.dmem_rvalid = 0;
      chk($sformatf("drain%0d_pending", i), 32'(bus.pending_mask), 32'(masks1[i]));
      chk($sformatf("drain%0d_ld_ready", i), 32'(bus.ld_ready), 32'd1);
    end
    cyc();

    // Pointer wrap: issue one, then issue-and-return together
    for (int k = 0; k < 6; k++) begin
      bus.ld_issue = 1; bus.ld_rd = 4'(8 + k);
      bus.dmem_rvalid = (k > 0);
      bus.dmem_rdata  = 32'hB0 + 32'(k) - 32'd1;
      if (k > 0) expect_wr(4'(8 + k - 1), 32'hB0 + 32'(k) - 32'd1);
      cyc();
      chk($sformatf("wrap%0d_pending", k), 32'(bus.pending_mask), 32'd1 << (8 + k));
    end
    bus.ld_issue = 0;
    bus.dmem_rvalid = 1; bus.dmem_rdata = 32'hB5;
    expect_wr(4'd13, 32'hB5);
    cyc();
    bus.dmem_rvalid = 0;
    chk("wrap_end_pending", 32'(bus.pending_mask), 32'd0);
    cyc();

    // Full plus simultaneous issue and return
    for (int i = 0; i < 4; i++) begin
      bus.ld_issue = 1; bus.ld_rd = 4'(i + 1);
      cyc();
    end
    bus.ld_issue = 0;
    chk("fs_pre_pending", 32'(bus.pending_mask), 32'h001E);
    bus.ld_issue = 1; bus.ld_rd = 4'd7;
    bus.dmem_rvalid = 1; bus.dmem_rdata = 32'hC1;
    expect_wr(4'd1, 32'hC1);
    cyc();
    bus.ld_issue = 0; bus.dmem_rvalid = 0;
    chk("fs_ld_ready", 32'(bus.ld_ready),     32'd0);
    chk("fs_pending",  32'(bus.pending_mask), 32'h009C);
    for (int i = 0; i < 4; i++) begin
      bus.dmem_rvalid = 1; bus.dmem_rdata = 32'hC2 + 32'(i);
      expect_wr(rds2[i], 32'hC2 + 32'(i));
      cyc();
    end
    bus.dmem_rvalid = 0;
    chk("fs_end_pending",  32'(bus.pending_mask), 32'd0);
    chk("fs_end_ld_ready", 32'(bus.ld_ready),     32'd1);
    cyc();

    // PC write
    bus.alu_valid = 1; bus.alu_rd = 4'd15; bus.alu_result = 32'h100;
    expect_wr(4'd15, 32'h100);
    cyc();
    bus.alu_valid = 0;
    chk("pc_wr_set", 32'(bus.pc_wr), 32'd1);
    cyc();
    chk("pc_wr_clear", 32'(bus.pc_wr), 32'd0);

    // Orphan return
    chk("orphan_pre", 32'(bus.err_orphan), 32'd0);
    bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h55;
    cyc();
    bus.dmem_rvalid = 0;
    chk("orphan_no_wr",  32'(bus.wr_en),      32'd0);
    chk("orphan_set",    32'(bus.err_orphan), 32'd1);
    cyc(); cyc(); cyc();
    chk("orphan_sticky", 32'(bus.err_orphan), 32'd1);

    // Reset mid-stream with skid full, loads pending and a write on the port
    bus.ld_issue = 1; bus.ld_rd = 4'd9;
    cyc();
    bus.ld_rd = 4'd10;
    cyc();
    bus.ld_issue = 0;
    bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h99;
    bus.alu_valid = 1; bus.alu_rd = 4'd4; bus.alu_result = 32'h44;
    cyc();
    bus.dmem_rvalid = 0; bus.alu_valid = 0;
    chk("mid_pre_alu_ready", 32'(bus.alu_ready),    32'd0);
    chk("mid_pre_pending",   32'(bus.pending_mask), 32'h0400);
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    chk("post_rst_wr_en",   32'(bus.wr_en),        32'd0);
    chk("post_rst_pending", 32'(bus.pending_mask), 32'd0);

    cyc(); cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
